// File: rtl/clic_reg_pkg.sv
// Shared CLIC register-adapter definitions: source count and claim-ID type.
package clic_reg_pkg;

    localparam int NumSrc  = 32;
    localparam int SrcIdxW = $clog2(NumSrc);

    typedef logic [SrcIdxW-1:0] clic_src_idx_t;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } clic_trig_e;

endpackage

// File: rtl/clic_gateway_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines, synchronous active-high reset.
module clic_gateway_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the raw lines into the clk_i domain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d_i;
            sync_r <= meta_r;
        end
    end

    assign q_o = sync_r;

endmodule

// File: rtl/clic_gateway.sv
// Per-source interrupt gateway (edge/level trigger) feeding the CLIC adapter ip_i.
// Optional input synchronisers enabled by defining CLIC_GATEWAY_SYNC_EN.
module clic_gateway
    import clic_reg_pkg::*;
#(
    parameter int N_SOURCE  = NumSrc,
    parameter int SRC_IDX_W = $clog2(N_SOURCE)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_SOURCE-1:0]  intsrc_i,
    input  logic [N_SOURCE-1:0]  le_i,
    input  logic [N_SOURCE-1:0]  sw_set_i,
    input  logic [N_SOURCE-1:0]  sw_clr_i,
    input  logic                 claim_valid_i,
    input  logic [SRC_IDX_W-1:0] claim_id_i,
    output logic [N_SOURCE-1:0]  ip_o,
    output logic                 claim_err_o
);

    logic [N_SOURCE-1:0] s_s;
    logic [N_SOURCE-1:0] s_q_r;
    logic [N_SOURCE-1:0] ip_r;
    logic [N_SOURCE-1:0] ip_nxt_s;
    logic [N_SOURCE-1:0] rise_s;
    logic [N_SOURCE-1:0] id_hit_s;
    logic                claim_ok_s;
    logic                claim_err_r;
    logic [1:0]          arm_cnt_r;
    logic                edge_en_s;

    // Edges are blanked until the sample pipeline has refilled after reset, so a
    // line held high through reset never looks like a fresh rising edge.
`ifdef CLIC_GATEWAY_SYNC_EN
    localparam logic [1:0] ARM_CYC = 2'd3;

    clic_gateway_sync #(
        .WIDTH (N_SOURCE)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (intsrc_i),
        .q_o   (s_s)
    );
`else
    localparam logic [1:0] ARM_CYC = 2'd1;

    assign s_s = intsrc_i;
`endif

    assign edge_en_s  = (arm_cnt_r == ARM_CYC);
    assign rise_s     = s_s & ~s_q_r & {N_SOURCE{edge_en_s}};
    assign claim_ok_s = claim_valid_i & (|(id_hit_s & ip_r));

    genvar k;
    generate
        for (k = 0; k < N_SOURCE; k++) begin : g_src
            logic nxt_s;

            assign id_hit_s[k] = (claim_id_i == SRC_IDX_W'(k));

            // Per-source next pending state: set beats clear in edge mode
            always_comb begin
                nxt_s = ip_r[k];
                if (le_i[k]) begin
                    if (rise_s[k] | sw_set_i[k]) begin
                        nxt_s = 1'b1;
                    end else if ((claim_ok_s & id_hit_s[k]) | sw_clr_i[k]) begin
                        nxt_s = 1'b0;
                    end else begin
                        nxt_s = ip_r[k];
                    end
                end else begin
                    nxt_s = s_s[k];
                end
            end

            assign ip_nxt_s[k] = nxt_s;
        end
    endgenerate

    // Sample history, pending vector, claim error pulse and post-reset arming
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q_r       <= {N_SOURCE{1'b0}};
            ip_r        <= {N_SOURCE{1'b0}};
            claim_err_r <= 1'b0;
            arm_cnt_r   <= 2'd0;
        end else begin
            s_q_r       <= s_s;
            ip_r        <= ip_nxt_s;
            claim_err_r <= claim_valid_i & ~claim_ok_s;
            if (arm_cnt_r != ARM_CYC) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
        end
    end

    assign ip_o        = ip_r;
    assign claim_err_o = claim_err_r;

endmodule
